// File: rtl/bnn_pkg.sv
// bnn_pkg: shared types and width helpers for the BNN adder-tree sequencer.
//   state_t : controller states (IDLE, RUN, DRAIN, DONE)
//   res_t   : {activation, neuron sum} record at the default layer widths
//   tree_w  : adder-tree output width for a given WIDTH_IN
//   acc_w   : neuron accumulator width for a given WIDTH_IN and CHUNK_W
package bnn_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic int tree_w(input int width_in);
        return width_in + 11;
    endfunction

    function automatic int acc_w(input int width_in, input int chunk_w);
        return tree_w(width_in) + chunk_w;
    endfunction

    localparam int RES_SUM_W = acc_w(8, 8);

    typedef struct packed {
        logic                        act;
        logic signed [RES_SUM_W-1:0] sum;
    } res_t;

endpackage

// File: rtl/bnn_res_fifo.sv
// bnn_res_fifo: synchronous FIFO with occupancy count, async active-high reset.
//   clk, rst         : clock, asynchronous reset (clears storage and pointers)
//   push, push_data  : write request and data (dropped only when full without a pop)
//   pop              : read request (ignored when empty)
//   head             : registered entry at the read pointer
//   count            : number of stored entries, 0..DEPTH
module bnn_res_fifo #(
    parameter int  W     = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [AW:0]  count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && count != '0;
    // A pop in the same cycle frees the slot, so a push at full is still legal.
    assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) mem[wr_ptr] <= push_data;
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/bnn_tree_sequencer.sv
// bnn_tree_sequencer: issues XNOR-popcount chunks into a fixed-latency adder
// tree, accumulates per-neuron sums at the tree output, thresholds them and
// buffers the activations for the layer output writer.
//   clk, rst                        : clock, asynchronous active-high reset
//   cfg_valid/cfg_ready             : layer config handshake (accepted in IDLE)
//   cfg_num_chunks/num_neurons      : chunks per neuron, neurons per layer
//   cfg_threshold                   : signed activation threshold
//   in_valid/in_ready               : chunk issue handshake from the streamer
//   tree_in_valid                   : tree captures its inputs this edge
//   tree_sum                        : tree output, TREE_LAT edges after issue
//   res_valid/res_ready             : result FIFO head handshake
//   res_bit, res_sum                : activation and full neuron sum at the head
//   busy, done                      : layer in progress, completion pulse
module bnn_tree_sequencer
    import bnn_pkg::*;
#(
    parameter int  WIDTH_IN  = 8,
    parameter int  TREE_LAT  = 7,
    parameter int  CHUNK_W   = 8,
    parameter int  ACC_W     = acc_w(WIDTH_IN, CHUNK_W),
    parameter int  RES_DEPTH = 4,
    localparam int TW        = tree_w(WIDTH_IN),
    localparam int CW        = $clog2(RES_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CHUNK_W-1:0]      cfg_num_chunks,
    input  logic [CHUNK_W-1:0]      cfg_num_neurons,
    input  logic signed [ACC_W-1:0] cfg_threshold,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    tree_in_valid,
    input  logic signed [TW-1:0]    tree_sum,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    res_bit,
    output logic signed [ACC_W-1:0] res_sum,
    output logic                    busy,
    output logic                    done
);

    state_t                  state;
    logic [CHUNK_W-1:0]      num_chunks;
    logic [CHUNK_W-1:0]      num_neurons;
    logic [CHUNK_W-1:0]      chunk_cnt;
    logic [CHUNK_W-1:0]      neuron_cnt;
    logic signed [ACC_W-1:0] threshold;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] sum_ext;
    logic [TREE_LAT-1:0]     p_v;
    logic [TREE_LAT-1:0]     p_f;
    logic [TREE_LAT-1:0]     p_l;
    logic [CW-1:0]           fifo_count;
    logic [ACC_W:0]          head;
    logic                    last_chunk;
    logic                    last_neuron;
    logic                    credit;
    logic                    issue;
    logic                    tail_v;
    logic                    push;
    logic                    pop;
    int                      tokens;

    assign last_chunk    = chunk_cnt == num_chunks - CHUNK_W'(1);
    assign last_neuron   = neuron_cnt == num_neurons - CHUNK_W'(1);

    // Every neuron still in the tree reserves a FIFO slot, so a result never
    // reaches a full FIFO and the free-running tree never has to stall.
    always_comb begin
        tokens = int'(fifo_count);
        for (int i = 0; i < TREE_LAT; i++) tokens += int'(p_v[i] & p_l[i]);
    end

    assign credit        = tokens < RES_DEPTH;
    assign in_ready      = state == RUN && (!last_chunk || credit);
    assign issue         = in_valid && in_ready;
    assign tree_in_valid = issue;

    assign tail_v        = p_v[TREE_LAT-1];
    assign sum_ext       = ACC_W'(tree_sum);
    assign acc_next      = p_f[TREE_LAT-1] ? sum_ext : acc + sum_ext;
    assign push          = tail_v && p_l[TREE_LAT-1];
    assign pop           = res_valid && res_ready;

    assign res_valid     = fifo_count != '0;
    assign {res_bit, res_sum} = head;
    assign cfg_ready     = state == IDLE;
    assign busy          = state != IDLE;
    assign done          = state == DONE;

    bnn_res_fifo #(
        .W     (ACC_W + 1),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({acc_next >= threshold, acc_next}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            num_chunks  <= '0;
            num_neurons <= '0;
            threshold   <= '0;
            chunk_cnt   <= '0;
            neuron_cnt  <= '0;
            p_v         <= '0;
            p_f         <= '0;
            p_l         <= '0;
            acc         <= '0;
        end else begin
            // Tag pipe mirrors the tree: index 0 is the newest issue, the top bit
            // lines up with tree_sum.
            p_v <= TREE_LAT'({p_v, issue});
            p_f <= TREE_LAT'({p_f, chunk_cnt == '0});
            p_l <= TREE_LAT'({p_l, last_chunk});
            if (tail_v) acc <= acc_next;
            case (state)
                IDLE: if (cfg_valid) begin
                    num_chunks  <= cfg_num_chunks;
                    num_neurons <= cfg_num_neurons;
                    threshold   <= cfg_threshold;
                    chunk_cnt   <= '0;
                    neuron_cnt  <= '0;
                    state       <= (cfg_num_chunks == '0 || cfg_num_neurons == '0) ? DONE : RUN;
                end
                RUN: if (issue) begin
                    chunk_cnt <= last_chunk ? '0 : chunk_cnt + CHUNK_W'(1);
                    if (last_chunk) neuron_cnt <= neuron_cnt + CHUNK_W'(1);
                    if (last_chunk && last_neuron) state <= DRAIN;
                end
                DRAIN: if (p_v == '0 && fifo_count == '0) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_tree_sequencer.sv
// tb_bnn_tree_sequencer: table vectors, corner sequences and random layers against a scoreboard.
module tb_bnn_tree_sequencer;

    localparam int WIDTH_IN  = 8;
    localparam int TREE_LAT  = 7;
    localparam int CHUNK_W   = 8;
    localparam int ACC_W     = WIDTH_IN + 11 + CHUNK_W;
    localparam int RES_DEPTH = 4;
    localparam int TW        = WIDTH_IN + 11;

    logic                    clk = 0;
    logic                    rst;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [CHUNK_W-1:0]      cfg_num_chunks;
    logic [CHUNK_W-1:0]      cfg_num_neurons;
    logic signed [ACC_W-1:0] cfg_threshold;
    logic                    in_valid;
    logic                    in_ready;
    logic                    tree_in_valid;
    logic signed [TW-1:0]    tree_sum;
    logic                    res_valid;
    logic                    res_ready;
    logic                    res_bit;
    logic signed [ACC_W-1:0] res_sum;
    logic                    busy;
    logic                    done;

    bnn_tree_sequencer #(
        .WIDTH_IN  (WIDTH_IN),
        .TREE_LAT  (TREE_LAT),
        .CHUNK_W   (CHUNK_W),
        .ACC_W     (ACC_W),
        .RES_DEPTH (RES_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_num_chunks  (cfg_num_chunks),
        .cfg_num_neurons (cfg_num_neurons),
        .cfg_threshold   (cfg_threshold),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .tree_in_valid   (tree_in_valid),
        .tree_sum        (tree_sum),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_bit         (res_bit),
        .res_sum         (res_sum),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Stand-in for the free-running adder tree: the chunk value on its inputs
    // appears on tree_sum TREE_LAT edges later, regardless of validity.
    logic signed [TW-1:0] cur_val;
    logic signed [TW-1:0] tree_pipe [TREE_LAT];

    always @(posedge clk) begin
        tree_pipe[0] <= cur_val;
        for (int i = 1; i < TREE_LAT; i++) tree_pipe[i] <= tree_pipe[i-1];
    end

    assign tree_sum = tree_pipe[TREE_LAT-1];

    typedef struct {
        int nc;
        int thr;
        int v0;
        int v1;
        int v2;
        int exp_sum;
        int exp_bit;
    } vec_t;

    vec_t                 tbl [10];
    int                   vectors = 0;
    int                   miscompares = 0;
    int                   vals [$];
    logic signed [63:0]   got_sum [$];
    logic                 got_bit [$];
    int                   issues;
    int                   first_issue_cyc;
    int                   first_res_cyc;
    int                   last_pop_cyc;
    int                   done_cyc;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic configure(input int nc, input int nn, input int thr);
        @(negedge clk);
        cfg_valid       = 1;
        cfg_num_chunks  = CHUNK_W'(nc);
        cfg_num_neurons = CHUNK_W'(nn);
        cfg_threshold   = ACC_W'(thr);
        #1 check("cfg_ready in idle", cfg_ready, 1);
    endtask

    // Runs one layer using the values in vals (issue order). The model sums
    // each group of nc issued chunks and expects popped results in that order.
    task automatic run_layer(input int nc, input int nn, input int thr, input bit rnd,
                             input int hold, input int exp_hold);
        logic signed [63:0] exp_q [$];
        longint run;
        int idx, ci, cyc, dones;
        run = 0; idx = 0; ci = 0; cyc = 0; dones = 0;
        issues = 0; first_issue_cyc = -1; first_res_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
        got_sum.delete();
        got_bit.delete();
        configure(nc, nn, thr);
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            cfg_valid = 0;
            if (done) begin
                dones++;
                done_cyc = cyc;
                break;
            end
            if (hold > 0 && cyc == hold) begin
                check("issues while stalled", issues, exp_hold);
                check("in_ready while stalled", in_ready, 0);
            end
            in_valid  = idx < vals.size() && (!rnd || $urandom_range(0, 3) != 0);
            cur_val   = idx < vals.size() ? TW'(vals[idx]) : '0;
            res_ready = cyc > hold && (!rnd || $urandom_range(0, 1) == 1);
            #1;
            if (res_valid && first_res_cyc < 0) first_res_cyc = cyc;
            if (tree_in_valid) begin
                if (first_issue_cyc < 0) first_issue_cyc = cyc;
                issues++;
                if (idx < vals.size()) begin
                    run += vals[idx];
                    idx++;
                    ci++;
                    if (ci == nc) begin
                        exp_q.push_back(run);
                        run = 0;
                        ci = 0;
                    end
                end
            end
            if (res_valid && res_ready) begin
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) check("spurious result", res_valid, 0);
                else begin
                    check("res_sum vs model", res_sum, exp_q[0]);
                    check("res_bit vs model", res_bit, exp_q[0] >= thr);
                    got_sum.push_back(res_sum);
                    got_bit.push_back(res_bit);
                    void'(exp_q.pop_front());
                end
            end
        end
        in_valid  = 0;
        res_ready = 0;
        check("layer done pulse", dones, 1);
        check("issued chunks", issues, vals.size());
        check("results outstanding", exp_q.size(), 0);
        @(negedge clk);
        check("done one cycle", done, 0);
        check("cfg_ready after done", cfg_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cfg_ready"}, cfg_ready, 1);
        check({tag, " in_ready"}, in_ready, 0);
        check({tag, " tree_in_valid"}, tree_in_valid, 0);
        check({tag, " res_valid"}, res_valid, 0);
        check({tag, " res_bit"}, res_bit, 0);
        check({tag, " res_sum"}, res_sum, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, cyc, stale, nc, nn, thr;
        rst = 1; cfg_valid = 0; cfg_num_chunks = '0; cfg_num_neurons = '0; cfg_threshold = '0;
        in_valid = 0; res_ready = 0; cur_val = '0;
        tbl[0] = '{1, 0, 5, 0, 0, 5, 1};
        tbl[1] = '{3, 0, 10, -4, -7, -1, 0};
        tbl[2] = '{1, 12, 12, 0, 0, 12, 1};
        tbl[3] = '{1, 12, 11, 0, 0, 11, 0};
        tbl[4] = '{2, -5, -3, -2, 0, -5, 1};
        tbl[5] = '{3, 300, 100, 100, 100, 300, 1};
        tbl[6] = '{3, 301, 100, 100, 100, 300, 0};
        tbl[7] = '{2, -1000, -600, -401, 0, -1001, 0};
        tbl[8] = '{3, 0, 262143, 262143, 262143, 786429, 1};
        tbl[9] = '{3, 0, -262144, -262144, -262144, -786432, 0};
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 0;

        // Single-chunk latency and done-after-pop.
        vals = '{5};
        run_layer(1, 1, 0, 0, 0, 0);
        check("latency edges", first_res_cyc - first_issue_cyc - 1, TREE_LAT);
        check("done two edges after pop", done_cyc - last_pop_cyc, 2);
        check("latency result count", got_sum.size(), 1);

        for (int t = 0; t < 10; t++) begin
            vals.delete();
            vals.push_back(tbl[t].v0);
            if (tbl[t].nc > 1) vals.push_back(tbl[t].v1);
            if (tbl[t].nc > 2) vals.push_back(tbl[t].v2);
            run_layer(tbl[t].nc, 1, tbl[t].thr, 0, 0, 0);
            check($sformatf("tbl%0d count", t), got_sum.size(), 1);
            if (got_sum.size() > 0) begin
                check($sformatf("tbl%0d sum", t), got_sum[0], tbl[t].exp_sum);
                check($sformatf("tbl%0d bit", t), got_bit[0], tbl[t].exp_bit);
            end
        end

        // Backpressure: only RES_DEPTH single-chunk neurons may be in flight.
        vals = '{3, -1, 7, 0, -9, 4};
        run_layer(1, 6, 0, 0, 30, RES_DEPTH);
        check("backpressure result count", got_sum.size(), 6);

        // Empty layers go straight to DONE.
        vals.delete();
        run_layer(0, 3, 0, 0, 0, 0);
        check("zero chunks done cycle", done_cyc, 1);
        run_layer(2, 0, 0, 0, 0, 0);
        check("zero neurons done cycle", done_cyc, 1);

        // Reset with three chunks in flight.
        configure(3, 2, 0);
        cnt = 0;
        cyc = 0;
        while (cnt < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            cfg_valid = 0;
            in_valid  = 1;
            cur_val   = TW'(100);
            #1 if (tree_in_valid) cnt++;
        end
        in_valid = 0;
        check("chunks issued before reset", cnt, 3);
        @(negedge clk);
        rst = 1;
        #1 check_reset_outputs("mid-run reset");
        @(negedge clk);
        rst = 0;
        stale = 0;
        repeat (15) begin
            @(negedge clk);
            if (res_valid || tree_in_valid) stale++;
        end
        check("stale activity after reset", stale, 0);
        vals = '{10, -4, -7};
        run_layer(3, 1, 0, 0, 0, 0);
        check("post-reset count", got_sum.size(), 1);
        if (got_sum.size() > 0) check("post-reset sum", got_sum[0], -1);

        // Random layers with random issue and pop handshakes.
        for (int l = 0; l < 6; l++) begin
            nc  = int'($urandom_range(1, 4));
            nn  = int'($urandom_range(1, 5));
            thr = int'($urandom_range(0, 600)) - 300;
            vals.delete();
            for (int i = 0; i < nc * nn; i++) vals.push_back(int'($urandom_range(0, 400)) - 200);
            run_layer(nc, nn, thr, 1, 0, 0);
            check($sformatf("random layer %0d count", l), got_sum.size(), nn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
